// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch-to-decode handshake bundle for inst_queue
//
// Purpose: groups the fetch-side push signals, the decode-side pop
// signals and flush into one bundle.
// master : fetch/decode side (drives packets, out_take and flush)
// slave  : the queue (drives in_rdy and the two output slots)
interface inst_queue_if;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [1:0]  in_cnt;
  logic [31:0] in_pc;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [1:0]  out_vld;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic [1:0]  out_take;

  modport master (
    output flush, in_vld, in_cnt, in_pc, in_inst0, in_inst1, out_take,
    input  in_rdy, out_vld, out_inst0, out_inst1, out_pc0, out_pc1
  );

  modport slave (
    input  flush, in_vld, in_cnt, in_pc, in_inst0, in_inst1, out_take,
    output in_rdy, out_vld, out_inst0, out_inst1, out_pc0, out_pc1
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction queue between fetch and decode
//
// Purpose: circular buffer of DEPTH single-instruction entries {inst, pc}.
// Accepts packets of 1 or 2 instructions, presents the two oldest entries
// to the decoders and pops 0..2 per cycle. flush empties the queue.
// Optional macro SRV_IQ_BYPASS_EN: an empty queue forwards the incoming
// packet to the outputs in the same cycle and stores only the part that
// decode did not consume.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   q     : inst_queue_if.slave (flush, in_* push side, out_* pop side)
module inst_queue #(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  inst_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr1;
  logic [CNT_W-1:0] count;

  logic             push;
  logic [1:0]       skip;
  logic [1:0]       wr_n;
  logic [1:0]       pop_n;
  logic [31:0]      pc1_in;
  logic [31:0]      w_inst0;
  logic [31:0]      w_pc0;
  logic [1:0]       q_vld;

  assign pc1_in  = q.in_pc + 32'd4;
  assign rd_ptr1 = rd_ptr + PTR_W'(1);

  // Room for a full two-instruction packet, from registered count only so
  // fetch never sees a combinational path from decode's out_take.
  assign q.in_rdy = (count <= CNT_W'(DEPTH - 2));
  assign push     = q.in_vld & q.in_rdy & ~q.flush;

  assign q_vld = (count == '0)          ? 2'b00 :
                 (count == CNT_W'(1))   ? 2'b01 : 2'b11;

`ifdef SRV_IQ_BYPASS_EN
  logic bypass;
  // flush already blocks push, so a flush cycle never bypasses.
  assign bypass = push && (count == '0);
  // In bypass the consumed instructions come from the packet, not storage.
  assign skip   = bypass ? q.out_take : 2'd0;
  assign pop_n  = (bypass || q.flush) ? 2'd0 : q.out_take;

  assign q.out_vld   = bypass ? ((q.in_cnt == 2'd2) ? 2'b11 : 2'b01) : q_vld;
  assign q.out_inst0 = bypass ? q.in_inst0 : mem_inst[rd_ptr];
  assign q.out_inst1 = bypass ? q.in_inst1 : mem_inst[rd_ptr1];
  assign q.out_pc0   = bypass ? q.in_pc    : mem_pc[rd_ptr];
  assign q.out_pc1   = bypass ? pc1_in     : mem_pc[rd_ptr1];
`else
  assign skip  = 2'd0;
  assign pop_n = q.flush ? 2'd0 : q.out_take;

  assign q.out_vld   = q_vld;
  assign q.out_inst0 = mem_inst[rd_ptr];
  assign q.out_inst1 = mem_inst[rd_ptr1];
  assign q.out_pc0   = mem_pc[rd_ptr];
  assign q.out_pc1   = mem_pc[rd_ptr1];
`endif

  assign wr_n = push ? (q.in_cnt - skip) : 2'd0;

  // First written entry is inst1 when inst0 was consumed via bypass.
  assign w_inst0 = skip[0] ? q.in_inst1 : q.in_inst0;
  assign w_pc0   = skip[0] ? pc1_in     : q.in_pc;

  // Entry storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) begin
      mem_inst[wr_ptr] <= w_inst0;
      mem_pc[wr_ptr]   <= w_pc0;
    end
    if (wr_n == 2'd2) begin
      mem_inst[wr_ptr + PTR_W'(1)] <= q.in_inst1;
      mem_pc[wr_ptr + PTR_W'(1)]   <= pc1_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(wr_n);
      count  <= count + CNT_W'(wr_n) - CNT_W'(pop_n);
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  inst_queue_if iq ();

  inst_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n)
    iq.in_vld |-> (iq.in_cnt == 2'd1 || iq.in_cnt == 2'd2));

  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (iq.out_take <= ((iq.out_vld == 2'b11) ? 2'd2 :
                     (iq.out_vld == 2'b01) ? 2'd1 : 2'd0)));

  a_vld_order: assert property (@(posedge clk) disable iff (!rst_n)
    !(iq.out_vld[1] && !iq.out_vld[0]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] cnt, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] take, input logic fl);
    iq.in_vld   = vld;
    iq.in_cnt   = cnt;
    iq.in_pc    = pc;
    iq.in_inst0 = i0;
    iq.in_inst1 = i1;
    iq.out_take = take;
    iq.flush    = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd1, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] cnt, input logic [31:0] pc);
    drive(1'b1, cnt, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, 2'd0, 1'b0);
    step();
    idle();
  endtask

  task automatic take(input logic [1:0] n);
    drive(1'b0, 2'd1, 32'd0, 32'd0, 32'd0, n, 1'b0);
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_vld", 32'(iq.out_vld), 32'h0);
    check("rst_rdy", 32'(iq.in_rdy), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First packet, one cycle latency
    drive(1'b1, 2'd2, 32'h100, 32'h0000_0013, 32'h0010_0093, 2'd0, 1'b0);
    step();
    idle();
    check("p1_vld",   32'(iq.out_vld), 32'h3);
    check("p1_pc0",   iq.out_pc0, 32'h100);
    check("p1_pc1",   iq.out_pc1, 32'h104);
    check("p1_inst0", iq.out_inst0, 32'h0000_0013);
    check("p1_inst1", iq.out_inst1, 32'h0010_0093);
    take(2'd2);
    check("p1_drain", 32'(iq.out_vld), 32'h0);

    // Single-instruction packet
    push(2'd1, 32'h200);
    check("odd_vld", 32'(iq.out_vld), 32'h1);
    check("odd_pc0", iq.out_pc0, 32'h200);
    take(2'd1);
    check("odd_drain", 32'(iq.out_vld), 32'h0);

    // Fill to DEPTH and watch in_rdy
    for (int i = 0; i < 4; i++) begin
      push(2'd2, 32'h1000 + 32'(8 * i));
      if (i == 2) check("fill_rdy6", 32'(iq.in_rdy), 32'h1);
    end
    check("full_rdy", 32'(iq.in_rdy), 32'h0);
    check("full_vld", 32'(iq.out_vld), 32'h3);
    take(2'd1);
    check("full7_rdy", 32'(iq.in_rdy), 32'h0);
    check("full7_pc0", iq.out_pc0, 32'h1004);
    check("full7_pc1", iq.out_pc1, 32'h1008);
    take(2'd1);
    check("full6_rdy", 32'(iq.in_rdy), 32'h1);
    check("full6_pc0", iq.out_pc0, 32'h1008);
    for (int i = 0; i < 3; i++) take(2'd2);
    check("full_drain", 32'(iq.out_vld), 32'h0);

    // Wrap-around with simultaneous push and pop; pointers start at 3
    push(2'd2, 32'h3000);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap%0d_vld", i), 32'(iq.out_vld), 32'h3);
      check($sformatf("wrap%0d_pc0", i), iq.out_pc0, 32'h3000 + 32'(8 * i));
      check($sformatf("wrap%0d_pc1", i), iq.out_pc1, 32'h3004 + 32'(8 * i));
      if (i < 4) begin
        drive(1'b1, 2'd2, 32'h3008 + 32'(8 * i), 32'h1, 32'h2, 2'd2, 1'b0);
      end else begin
        drive(1'b0, 2'd1, 32'd0, 32'd0, 32'd0, 2'd2, 1'b0);
      end
      step();
      idle();
    end
    check("wrap_drain", 32'(iq.out_vld), 32'h0);

    // Flush with push and pop in the same cycle, count = 3
    push(2'd2, 32'h4000);
    push(2'd1, 32'h4008);
    check("fl_pre_vld", 32'(iq.out_vld), 32'h3);
    check("fl_pre_pc0", iq.out_pc0, 32'h4000);
    drive(1'b1, 2'd2, 32'h5000, 32'h55, 32'h66, 2'd2, 1'b1);
    #1;
    check("fl_cyc_vld", 32'(iq.out_vld), 32'h3);
    step();
    idle();
    check("fl_post_vld", 32'(iq.out_vld), 32'h0);
    check("fl_post_rdy", 32'(iq.in_rdy), 32'h1);
    push(2'd1, 32'h6000);
    check("fl_next_vld", 32'(iq.out_vld), 32'h1);
    check("fl_next_pc0", iq.out_pc0, 32'h6000);
    take(2'd1);

`ifdef SRV_IQ_BYPASS_EN
    // Bypass: empty queue, push 2 and consume 1 in the same cycle
    drive(1'b1, 2'd2, 32'h7000, 32'h11, 32'h22, 2'd1, 1'b0);
    #1;
    check("byp_vld", 32'(iq.out_vld), 32'h3);
    check("byp_pc0", iq.out_pc0, 32'h7000);
    check("byp_pc1", iq.out_pc1, 32'h7004);
    step();
    idle();
    check("byp_next_vld", 32'(iq.out_vld), 32'h1);
    check("byp_next_pc0", iq.out_pc0, 32'h7004);
    check("byp_next_inst0", iq.out_inst0, 32'h22);
    take(2'd1);
`endif

    // Reset during a push
    push(2'd2, 32'h8000);
    drive(1'b1, 2'd2, 32'h9000, 32'h77, 32'h88, 2'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    iq.in_vld = 1'b0;
    #1;
    check("rst_mid_vld", 32'(iq.out_vld), 32'h0);
    check("rst_mid_rdy", 32'(iq.in_rdy), 32'h1);
    step();
    rst_n = 1'b1;
    check("rst_rel_vld", 32'(iq.out_vld), 32'h0);
    push(2'd1, 32'hA000);
    check("rst_after_vld", 32'(iq.out_vld), 32'h1);
    check("rst_after_pc0", iq.out_pc0, 32'hA000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
